// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
package mem_access_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] SRC_I    = 3'b100;
   localparam logic [2:0] SRC_D    = 3'b010;
   localparam logic [2:0] SRC_DL   = 3'b001;
   localparam logic [2:0] SRC_NONE = 3'b000;

   localparam int LINE_WORDS = 4;
   localparam int WORD_W     = 32;
   localparam int LINE_W     = 128;

   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        idx);
      logic [WORD_W-1:0] w;
      case (idx)
         2'd0:    w = line[31:0];
         2'd1:    w = line[63:32];
         2'd2:    w = line[95:64];
         2'd3:    w = line[127:96];
         default: w = 32'h0000_0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_line_buf.sv
// Read-assembly register: one 32-bit word written per cycle at a word index.
module mem_line_buf
   import mem_access_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [1:0]        i_idx,
   input  logic [WORD_W-1:0] i_word,
   output logic [LINE_W-1:0] o_line
);

   logic [LINE_W-1:0] r_line;

   // word-indexed capture of returning SRAM data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line <= {LINE_W{1'b0}};
      end else if (i_we) begin
         case (i_idx)
            2'd0:    r_line[31:0]   <= i_word;
            2'd1:    r_line[63:32]  <= i_word;
            2'd2:    r_line[95:64]  <= i_word;
            2'd3:    r_line[127:96] <= i_word;
            default: r_line         <= r_line;
         endcase
      end else begin
         r_line <= r_line;
      end
   end

   assign o_line = r_line;

endmodule

// File: rtl/mem_access_ctrl.sv
// Cache-line (4-word) read/write sequencer between the memory arbiter and a
// single-port synchronous SRAM. All SRAM-facing and arbiter-facing outputs are registered.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int MEM_AW = 14
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              v_i_m_areg_m,
   input  logic              v_d_m_areg_m,
   input  logic              v_m_download_m,
   input  logic [31:0]       i_m_areg_addr,
   input  logic [31:0]       d_m_areg_addr,
   input  logic              d_m_areg_we,
   input  logic [LINE_W-1:0] d_m_areg_wdata,
   input  logic [31:0]       m_download_addr,
   input  logic [LINE_W-1:0] m_download_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              mem_access_done,
   output logic [2:0]        done_src,
   output logic [LINE_W-1:0] mem_rd_line
);

   localparam int BASE_W = MEM_AW - 2;

   state_t              r_state,     w_nxt_state;
   logic [1:0]          r_k,         w_nxt_k;
   logic [2:0]          r_src,       w_nxt_src;
   logic [BASE_W-1:0]   r_base,      w_nxt_base;
   logic                r_we,        w_nxt_we;
   logic [LINE_W-1:0]   r_wline,     w_nxt_wline;
   logic                r_mem_en,    w_nxt_mem_en;
   logic                r_mem_we,    w_nxt_mem_we;
   logic [MEM_AW-1:0]   r_mem_addr,  w_nxt_mem_addr;
   logic [WORD_W-1:0]   r_mem_wdata, w_nxt_mem_wdata;
   logic                r_done,      w_nxt_done;
   logic [2:0]          r_done_src,  w_nxt_done_src;
   logic [LINE_W-1:0]   r_rd_line;

   logic                w_gnt_any;
   logic [2:0]          w_sel_src;
   logic [BASE_W-1:0]   w_sel_base;
   logic                w_sel_we;
   logic [LINE_W-1:0]   w_sel_wline;
   logic                w_cap_we;
   logic [1:0]          w_cap_idx;
   logic                w_rd_commit;
   logic [LINE_W-1:0]   w_asm_line;
   logic                w_unused;

   assign w_unused = ^{i_m_areg_addr[3:0], i_m_areg_addr[31:MEM_AW+4],
                       d_m_areg_addr[3:0], d_m_areg_addr[31:MEM_AW+4],
                       m_download_addr[3:0], m_download_addr[31:MEM_AW+4]};

   // fixed-priority request select: instruction > data > download
   always_comb begin
      w_gnt_any   = v_i_m_areg_m | v_d_m_areg_m | v_m_download_m;
      w_sel_src   = SRC_NONE;
      w_sel_base  = {BASE_W{1'b0}};
      w_sel_we    = 1'b0;
      w_sel_wline = {LINE_W{1'b0}};
      if (v_i_m_areg_m) begin
         w_sel_src  = SRC_I;
         w_sel_base = i_m_areg_addr[MEM_AW+3:4];
      end else if (v_d_m_areg_m) begin
         w_sel_src   = SRC_D;
         w_sel_base  = d_m_areg_addr[MEM_AW+3:4];
         w_sel_we    = d_m_areg_we;
         w_sel_wline = d_m_areg_wdata;
      end else if (v_m_download_m) begin
         w_sel_src   = SRC_DL;
         w_sel_base  = m_download_addr[MEM_AW+3:4];
         w_sel_we    = 1'b1;
         w_sel_wline = m_download_wdata;
      end else begin
         w_sel_src = SRC_NONE;
      end
   end

   // next state plus next value of every registered output
   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_k         = r_k;
      w_nxt_src       = r_src;
      w_nxt_base      = r_base;
      w_nxt_we        = r_we;
      w_nxt_wline     = r_wline;
      w_nxt_mem_en    = 1'b0;
      w_nxt_mem_we    = 1'b0;
      w_nxt_mem_addr  = r_mem_addr;
      w_nxt_mem_wdata = 32'h0000_0000;
      w_nxt_done      = 1'b0;
      w_nxt_done_src  = SRC_NONE;
      w_cap_we        = 1'b0;
      w_cap_idx       = 2'd0;
      w_rd_commit     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_any) begin
               w_nxt_state     = ST_BEAT;
               w_nxt_k         = 2'd0;
               w_nxt_src       = w_sel_src;
               w_nxt_base      = w_sel_base;
               w_nxt_we        = w_sel_we;
               w_nxt_wline     = w_sel_wline;
               w_nxt_mem_en    = 1'b1;
               w_nxt_mem_we    = w_sel_we;
               w_nxt_mem_addr  = {w_sel_base, 2'd0};
               w_nxt_mem_wdata = w_sel_we ? line_word(w_sel_wline, 2'd0) : 32'h0000_0000;
            end else begin
               w_nxt_state = ST_IDLE;
            end
         end
         ST_BEAT: begin
            // read data for beat k-1 arrives during beat k
            if (!r_we && (r_k != 2'd0)) begin
               w_cap_we  = 1'b1;
               w_cap_idx = r_k - 2'd1;
            end else begin
               w_cap_we = 1'b0;
            end
            if (r_k == 2'd3) begin
               if (r_we) begin
                  w_nxt_state    = ST_DONE;
                  w_nxt_done     = 1'b1;
                  w_nxt_done_src = r_src;
               end else begin
                  w_nxt_state = ST_DRAIN;
               end
            end else begin
               w_nxt_k         = r_k + 2'd1;
               w_nxt_mem_en    = 1'b1;
               w_nxt_mem_we    = r_we;
               w_nxt_mem_addr  = {r_base, r_k + 2'd1};
               w_nxt_mem_wdata = r_we ? line_word(r_wline, r_k + 2'd1) : 32'h0000_0000;
            end
         end
         ST_DRAIN: begin
            w_cap_we       = 1'b1;
            w_cap_idx      = 2'd3;
            w_rd_commit    = 1'b1;
            w_nxt_state    = ST_DONE;
            w_nxt_done     = 1'b1;
            w_nxt_done_src = r_src;
         end
         ST_DONE: begin
            w_nxt_state = ST_IDLE;
         end
         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   mem_line_buf u_line_buf (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_cap_we),
      .i_idx  (w_cap_idx),
      .i_word (mem_rdata),
      .o_line (w_asm_line)
   );

   // FSM, request latch and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_k         <= 2'd0;
         r_src       <= SRC_NONE;
         r_base      <= {BASE_W{1'b0}};
         r_we        <= 1'b0;
         r_wline     <= {LINE_W{1'b0}};
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {MEM_AW{1'b0}};
         r_mem_wdata <= 32'h0000_0000;
         r_done      <= 1'b0;
         r_done_src  <= SRC_NONE;
      end else begin
         r_state     <= w_nxt_state;
         r_k         <= w_nxt_k;
         r_src       <= w_nxt_src;
         r_base      <= w_nxt_base;
         r_we        <= w_nxt_we;
         r_wline     <= w_nxt_wline;
         r_mem_en    <= w_nxt_mem_en;
         r_mem_we    <= w_nxt_mem_we;
         r_mem_addr  <= w_nxt_mem_addr;
         r_mem_wdata <= w_nxt_mem_wdata;
         r_done      <= w_nxt_done;
         r_done_src  <= w_nxt_done_src;
      end
   end

   // published read line only changes when a read completes, never mid-assembly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_line <= {LINE_W{1'b0}};
      end else if (w_rd_commit) begin
         r_rd_line <= {mem_rdata, w_asm_line[95:0]};
      end else begin
         r_rd_line <= r_rd_line;
      end
   end

   assign mem_en          = r_mem_en;
   assign mem_we          = r_mem_we;
   assign mem_addr        = r_mem_addr;
   assign mem_wdata       = r_mem_wdata;
   assign mem_access_done = r_done;
   assign done_src        = r_done_src;
   assign mem_rd_line     = r_rd_line;

endmodule
